wb_arbiter: RTL and testbench

- Write-back stage of the NPC core, placed between the functional units and the register file write port.
- Accepts completed results from EXU and LSU over valid/ready handshakes and arbitrates them onto the single register file write port.
- Keeps a busy-bit scoreboard of pending destination registers, used by the decode/issue stage for RAW/WAW stalling.

---
 rtl/npc_wb_pkg.sv | 15 +
 rtl/wb_scoreboard.sv | 40 ++++
 rtl/wb_arbiter.sv | 114 +++++++++++
 tb/tb_wb_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_wb_pkg.sv
// Shared definitions for the NPC write-back stage: default widths,
// the LSU streak limit and the write-back source encoding.
package npc_wb_pkg;

    localparam int WB_ADDR_WIDTH     = 5;
    localparam int WB_DATA_WIDTH     = 32;
    localparam int WB_LSU_MAX_STREAK = 2;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_EXU  = 2'd1,
        WB_LSU  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy-bit scoreboard of pending destination registers plus the
// decode-stage stall query over three register indices.
module wb_scoreboard
    import npc_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         set_en,
    input  logic [ADDR_WIDTH-1:0]        set_idx,
    input  logic                         clr_en,
    input  logic [ADDR_WIDTH-1:0]        clr_idx,
    input  logic [ADDR_WIDTH-1:0]        q0_idx,
    input  logic [ADDR_WIDTH-1:0]        q1_idx,
    input  logic [ADDR_WIDTH-1:0]        q2_idx,
    output logic                         busy_any,
    output logic [(1<<ADDR_WIDTH)-1:0]   busy
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0] busy_nxt;

    // Set is applied after clear so a same-index set/clear leaves the bit busy.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_idx] = 1'b0;
        if (set_en) busy_nxt[set_idx] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    assign busy_any = busy[q0_idx] | busy[q1_idx] | busy[q2_idx];

endmodule

// File: rtl/wb_arbiter.sv
// NPC write-back stage: arbitrates EXU/LSU results onto the single register
// file write port and tracks pending destinations for issue stalling.
module wb_arbiter
    import npc_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int LSU_MAX_STREAK = WB_LSU_MAX_STREAK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  issue_stall,
    input  logic                  exu_valid,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    output logic                  exu_ready,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  wb_err
);

    localparam int         NREG     = 1 << ADDR_WIDTH;
    localparam logic [1:0] STREAK_M = 2'(LSU_MAX_STREAK);

    logic                  busy_any;
    logic [NREG-1:0]       busy;
    logic                  set_en;
    wb_src_e               sel;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] grant_rd;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [1:0]            lsu_streak;
    logic                  wen_p1;
    logic [ADDR_WIDTH-1:0] waddr_p1;
    logic [DATA_WIDTH-1:0] wdata_p1;
    logic                  err_q;

    assign issue_stall = busy_any & ~rst;
    assign set_en      = issue_valid & ~issue_stall & (issue_rd != '0);

    wb_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_idx  (issue_rd),
        .clr_en   (wen_p1),
        .clr_idx  (waddr_p1),
        .q0_idx   (rs1),
        .q1_idx   (rs2),
        .q2_idx   (issue_rd),
        .busy_any (busy_any),
        .busy     (busy)
    );

    // LSU wins ties until it has starved EXU for LSU_MAX_STREAK grants.
    always_comb begin
        sel = WB_NONE;
        if (!rst) begin
            if (lsu_valid && (!exu_valid || lsu_streak != STREAK_M)) sel = WB_LSU;
            else if (exu_valid)                                      sel = WB_EXU;
        end
    end

    assign exu_ready  = (sel == WB_EXU);
    assign lsu_ready  = (sel == WB_LSU);
    assign accept     = (sel != WB_NONE);
    assign grant_rd   = (sel == WB_LSU) ? lsu_rd   : exu_rd;
    assign grant_data = (sel == WB_LSU) ? lsu_data : exu_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_streak <= 2'd0;
        end else begin
            case (sel)
                WB_LSU:  lsu_streak <= !exu_valid ? 2'd0 :
                                       (lsu_streak == 2'd3) ? lsu_streak : lsu_streak + 2'd1;
                WB_EXU:  lsu_streak <= 2'd0;
                default: lsu_streak <= lsu_streak;
            endcase
        end
    end

    // Stage p1: registered write port; rd==0 consumes the grant but never writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
            err_q    <= 1'b0;
        end else begin
            wen_p1 <= accept && (grant_rd != '0);
            if (accept) begin
                waddr_p1 <= grant_rd;
                wdata_p1 <= grant_data;
            end
            if (accept && grant_rd != '0 && !busy[grant_rd]) err_q <= 1'b1;
        end
    end

    assign rf_wen   = wen_p1;
    assign rf_waddr = waddr_p1;
    assign rf_wdata = wdata_p1;
    assign wb_err   = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a cycle-level reference model and
// hand-computed expectations for each scenario.
module tb_wb_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int MAXS = 2;

    logic          clk;
    logic          rst;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          issue_stall;
    logic          exu_valid;
    logic [AW-1:0] exu_rd;
    logic [DW-1:0] exu_data;
    logic          exu_ready;
    logic          lsu_valid;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          lsu_ready;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          wb_err;

    int n_pass  = 0;
    int n_total = 0;

    wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LSU_MAX_STREAK(MAXS)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .issue_stall (issue_stall),
        .exu_valid   (exu_valid),
        .exu_rd      (exu_rd),
        .exu_data    (exu_data),
        .exu_ready   (exu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .wb_err      (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: pending registers as a bit array, the write in flight,
    // the sticky error and the number of consecutive LSU wins over a waiting EXU.
    bit          m_busy [NREG];
    int          m_streak;
    bit          m_wen;
    int          m_waddr;
    logic [31:0] m_wdata;
    bit          m_err;
    bit          m_live = 1'b0;

    function automatic int m_grant();  // 0 none, 1 EXU, 2 LSU
        if (rst) return 0;
        if (lsu_valid && exu_valid) return (m_streak >= MAXS) ? 1 : 2;
        if (lsu_valid) return 2;
        if (exu_valid) return 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        if (rst) return 1'b0;
        return m_busy[int'(rs1)] || m_busy[int'(rs2)] || m_busy[int'(issue_rd)];
    endfunction

    always @(posedge clk) begin : model
        int          g;
        int          rd;
        logic [31:0] d;
        bit          st;
        if (rst) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            m_streak = 0;
            m_wen    = 1'b0;
            m_waddr  = 0;
            m_wdata  = '0;
            m_err    = 1'b0;
            m_live   = 1'b1;
        end else begin
            g  = m_grant();
            st = m_stall();
            rd = (g == 2) ? int'(lsu_rd) : int'(exu_rd);
            d  = (g == 2) ? lsu_data : exu_data;
            if (g != 0 && rd != 0 && !m_busy[rd]) m_err = 1'b1;
            if (m_wen) m_busy[m_waddr] = 1'b0;
            if (issue_valid && !st && issue_rd != 0) m_busy[int'(issue_rd)] = 1'b1;
            if (g == 2 && exu_valid) m_streak = (m_streak < 3) ? m_streak + 1 : 3;
            else if (g != 0)         m_streak = 0;
            m_wen = (g != 0) && (rd != 0);
            if (g != 0) begin
                m_waddr = rd;
                m_wdata = d;
            end
        end
    end

    always @(negedge clk) begin : compare
        int g;
        if (m_live) begin
            g = m_grant();
            chk("m_exu_ready",   {31'd0, exu_ready},   {31'd0, g == 1});
            chk("m_lsu_ready",   {31'd0, lsu_ready},   {31'd0, g == 2});
            chk("m_issue_stall", {31'd0, issue_stall}, {31'd0, m_stall()});
            chk("m_rf_wen",      {31'd0, rf_wen},      {31'd0, m_wen});
            chk("m_rf_waddr",    {27'd0, rf_waddr},    32'(m_waddr));
            chk("m_rf_wdata",    rf_wdata,             m_wdata);
            chk("m_wb_err",      {31'd0, wb_err},      {31'd0, m_err});
        end
    end

    task automatic idle();
        issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
        exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    int    lrd [6] = '{10, 11, 12, 12, 13, 13};
    int    erd [6] = '{14, 14, 14, 15, 15, 15};
    bit    lwin[6] = '{1, 1, 0, 1, 1, 0};

    initial begin
        idle();
        rst = 1'b1;
        exu_valid = 1'b1; lsu_valid = 1'b1;
        next();
        at_neg();
        chk("rst_rf_wen",    {31'd0, rf_wen},    32'd0);
        chk("rst_wb_err",    {31'd0, wb_err},    32'd0);
        chk("rst_exu_ready", {31'd0, exu_ready}, 32'd0);
        chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        next();
        rst = 1'b0;
        idle();

        // Issue rd=5, EXU writes it back.
        issue_valid = 1'b1; issue_rd = 5'd5;
        at_neg(); chk("t1_issue_nostall", {31'd0, issue_stall}, 32'd0);
        next();
        issue_valid = 1'b0; issue_rd = '0; rs1 = 5'd5;
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
        at_neg();
        chk("t1_exu_ready", {31'd0, exu_ready},   32'd1);
        chk("t1_stall_N",   {31'd0, issue_stall}, 32'd1);
        next();
        exu_valid = 1'b0;
        at_neg();
        chk("t1_rf_wen",   {31'd0, rf_wen},      32'd1);
        chk("t1_rf_waddr", {27'd0, rf_waddr},    32'd5);
        chk("t1_rf_wdata", rf_wdata,             32'hDEADBEEF);
        chk("t1_stall_N1", {31'd0, issue_stall}, 32'd1);
        next();
        at_neg();
        chk("t1_stall_N2", {31'd0, issue_stall}, 32'd0);
        chk("t1_wen_N2",   {31'd0, rf_wen},      32'd0);
        next();
        idle();

        // Both sources continuously valid against busy destinations.
        for (int i = 10; i <= 15; i++) begin
            issue_valid = 1'b1; issue_rd = 5'(i);
            next();
        end
        idle();
        for (int i = 0; i < 6; i++) begin
            exu_valid = 1'b1; exu_rd = 5'(erd[i]); exu_data = 32'h1000 + 32'(i);
            lsu_valid = 1'b1; lsu_rd = 5'(lrd[i]); lsu_data = 32'h2000 + 32'(i);
            at_neg();
            chk("t2_lsu_grant", {31'd0, lsu_ready}, {31'd0, lwin[i]});
            chk("t2_exu_grant", {31'd0, exu_ready}, {31'd0, !lwin[i]});
            next();
        end
        idle();
        at_neg(); chk("t2_no_err", {31'd0, wb_err}, 32'd0);
        next();
        next();

        // rd=0 result is consumed without a write.
        exu_valid = 1'b1; exu_rd = '0; exu_data = 32'h1234;
        at_neg(); chk("t3_exu_ready", {31'd0, exu_ready}, 32'd1);
        next();
        idle();
        at_neg();
        chk("t3_rf_wen", {31'd0, rf_wen}, 32'd0);
        chk("t3_wb_err", {31'd0, wb_err}, 32'd0);
        next();

        // Write-back to a register that is not busy.
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h7777;
        at_neg();
        chk("t4_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        chk("t4_err_before", {31'd0, wb_err}, 32'd0);
        next();
        idle();
        at_neg();
        chk("t4_rf_wen",   {31'd0, rf_wen},   32'd1);
        chk("t4_rf_waddr", {27'd0, rf_waddr}, 32'd7);
        chk("t4_wb_err",   {31'd0, wb_err},   32'd1);
        next();
        next();
        at_neg(); chk("t4_err_sticky", {31'd0, wb_err}, 32'd1);
        next();

        // Back-to-back issue of rd=3 (WAW stall).
        issue_valid = 1'b1; issue_rd = 5'd3;
        at_neg(); chk("t5_first_issue", {31'd0, issue_stall}, 32'd0);
        next();
        at_neg(); chk("t5_second_stall", {31'd0, issue_stall}, 32'd1);
        next();
        exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h33;
        at_neg();
        chk("t5_exu_ready", {31'd0, exu_ready},   32'd1);
        chk("t5_stall_N",   {31'd0, issue_stall}, 32'd1);
        next();
        exu_valid = 1'b0;
        at_neg();
        chk("t5_rf_waddr",  {27'd0, rf_waddr},    32'd3);
        chk("t5_stall_N1",  {31'd0, issue_stall}, 32'd1);
        next();
        at_neg(); chk("t5_release_N2", {31'd0, issue_stall}, 32'd0);
        next();
        issue_valid = 1'b0;
        at_neg(); chk("t5_busy_again", {31'd0, issue_stall}, 32'd1);
        next();
        idle();

        // Reset one cycle after an EXU acceptance.
        issue_valid = 1'b1; issue_rd = 5'd9;
        next();
        idle();
        exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h99;
        at_neg(); chk("t6_exu_ready", {31'd0, exu_ready}, 32'd1);
        next();
        rst = 1'b1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; rs1 = 5'd9; rs2 = 5'd3;
        at_neg();
        chk("t6_rst_exu_ready", {31'd0, exu_ready},   32'd0);
        chk("t6_rst_lsu_ready", {31'd0, lsu_ready},   32'd0);
        chk("t6_rst_stall",     {31'd0, issue_stall}, 32'd0);
        next();
        rst = 1'b0;
        exu_valid = 1'b0; lsu_valid = 1'b0;
        at_neg();
        chk("t6_post_wen",   {31'd0, rf_wen},      32'd0);
        chk("t6_post_clear", {31'd0, issue_stall}, 32'd0);
        chk("t6_post_err",   {31'd0, wb_err},      32'd0);
        next();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd4;
        at_neg(); chk("t6_resume_issue", {31'd0, issue_stall}, 32'd0);
        next();
        idle();
        exu_valid = 1'b1; exu_rd = 5'd4; exu_data = 32'h44;
        at_neg(); chk("t6_resume_ready", {31'd0, exu_ready}, 32'd1);
        next();
        idle();
        at_neg();
        chk("t6_resume_wen",   {31'd0, rf_wen},   32'd1);
        chk("t6_resume_waddr", {27'd0, rf_waddr}, 32'd4);
        chk("t6_resume_wdata", rf_wdata,          32'h44);
        chk("t6_resume_err",   {31'd0, wb_err},   32'd0);
        next();
        next();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
